// File: rtl/fighter_action_sequencer_if.sv
// Signal bundle between the input block, one player's action sequencer and the physics engine.
// master drives ticks, buttons and floor/hit status; slave (the sequencer) returns commands.
interface fighter_action_sequencer_if;
  logic       tick;
  logic       btn_left;
  logic       btn_right;
  logic       btn_jump;
  logic       btn_attack;
  logic       on_floor;
  logic       hit_in;
  logic       movingLeft;
  logic       movingRight;
  logic       isJumping;
  logic       attack_active;
  logic       stunned;
  logic [2:0] state;

  modport master (
    output tick, btn_left, btn_right, btn_jump, btn_attack, on_floor, hit_in,
    input  movingLeft, movingRight, isJumping, attack_active, stunned, state
  );

  modport slave (
    input  tick, btn_left, btn_right, btn_jump, btn_attack, on_floor, hit_in,
    output movingLeft, movingRight, isJumping, attack_active, stunned, state
  );
endinterface

// File: rtl/fighter_action_sequencer.sv
// Per-player action sequencer: latches button edges and hits between 20 Hz ticks and
// advances walk/jump/attack/stun phases only on tick, so physics sees stable commands.
module fighter_action_sequencer #(
  parameter int ATK_STARTUP = 2,
  parameter int ATK_ACTIVE  = 3,
  parameter int ATK_RECOVER = 4,
  parameter int STUN_TICKS  = 6,
  parameter int CNT_W       = 4
) (
  input logic                       clk,
  input logic                       reset,
  fighter_action_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WALK  = 3'd1,
    S_JUMP  = 3'd2,
    S_ATK_S = 3'd3,
    S_ATK_A = 3'd4,
    S_ATK_R = 3'd5,
    S_STUN  = 3'd6
  } state_t;

  // Counters hold "ticks remaining after this one", so each phase loads length-1.
  localparam logic [CNT_W-1:0] L_ATK_S = CNT_W'(ATK_STARTUP - 1);
  localparam logic [CNT_W-1:0] L_ATK_A = CNT_W'(ATK_ACTIVE - 1);
  localparam logic [CNT_W-1:0] L_ATK_R = CNT_W'(ATK_RECOVER - 1);
  localparam logic [CNT_W-1:0] L_STUN  = CNT_W'(STUN_TICKS - 1);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_prev_jump;
  logic             r_prev_atk;
  logic             r_jump_req;
  logic             r_atk_req;
  logic             r_hit_req;
  logic             r_moving_left;
  logic             r_moving_right;
  logic             r_is_jumping;
  logic             r_attack_active;
  logic             r_stunned;

  logic             w_dir_left;
  logic             w_dir_right;
  logic             w_jump_pend;
  logic             w_atk_pend;
  logic             w_hit_pend;
  logic             w_launch;
  logic             w_moving_ok;
  state_t           w_next_state;
  logic [CNT_W-1:0] w_next_cnt;

  assign w_dir_left  = bus.btn_left & ~bus.btn_right;
  assign w_dir_right = bus.btn_right & ~bus.btn_left;

  // A press landing on the tick clk itself still counts for that tick.
  assign w_jump_pend = r_jump_req | (bus.btn_jump & ~r_prev_jump);
  assign w_atk_pend  = r_atk_req | (bus.btn_attack & ~r_prev_atk);
  assign w_hit_pend  = r_hit_req | bus.hit_in;

  always_comb begin
    w_next_state = S_IDLE;
    w_next_cnt   = r_cnt;
    w_launch     = 1'b0;
    case (r_state)
      S_IDLE, S_WALK: begin
        if (w_atk_pend) begin
          w_next_state = S_ATK_S;
          w_next_cnt   = L_ATK_S;
        end else if (w_jump_pend && bus.on_floor) begin
          w_next_state = S_JUMP;
          w_launch     = 1'b1;
        end else if (w_dir_left || w_dir_right) begin
          w_next_state = S_WALK;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      // Landing is ignored on the launch tick, while on_floor is still stale.
      S_JUMP: w_next_state = (bus.on_floor && !r_is_jumping) ? S_IDLE : S_JUMP;
      S_ATK_S: begin
        if (r_cnt == '0) begin
          w_next_state = S_ATK_A;
          w_next_cnt   = L_ATK_A;
        end else begin
          w_next_state = S_ATK_S;
          w_next_cnt   = r_cnt - 1'b1;
        end
      end
      S_ATK_A: begin
        if (r_cnt == '0) begin
          w_next_state = S_ATK_R;
          w_next_cnt   = L_ATK_R;
        end else begin
          w_next_state = S_ATK_A;
          w_next_cnt   = r_cnt - 1'b1;
        end
      end
      S_ATK_R: begin
        if (r_cnt == '0) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_ATK_R;
          w_next_cnt   = r_cnt - 1'b1;
        end
      end
      S_STUN: begin
        if (r_cnt == '0) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_STUN;
          w_next_cnt   = r_cnt - 1'b1;
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_cnt   = '0;
      end
    endcase
    // Hits preempt every legal phase except an ongoing stun, which is never extended.
    if (w_hit_pend && (r_state < S_STUN)) begin
      w_next_state = S_STUN;
      w_next_cnt   = L_STUN;
      w_launch     = 1'b0;
    end
  end

  assign w_moving_ok = (w_next_state == S_WALK) || (w_next_state == S_JUMP);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_prev_jump     <= 1'b0;
      r_prev_atk      <= 1'b0;
      r_jump_req      <= 1'b0;
      r_atk_req       <= 1'b0;
      r_hit_req       <= 1'b0;
      r_moving_left   <= 1'b0;
      r_moving_right  <= 1'b0;
      r_is_jumping    <= 1'b0;
      r_attack_active <= 1'b0;
      r_stunned       <= 1'b0;
    end else begin
      r_prev_jump <= bus.btn_jump;
      r_prev_atk  <= bus.btn_attack;
      if (bus.tick) begin
        r_state         <= w_next_state;
        r_cnt           <= w_next_cnt;
        r_jump_req      <= 1'b0;
        r_atk_req       <= 1'b0;
        r_hit_req       <= 1'b0;
        r_moving_left   <= w_dir_left & w_moving_ok;
        r_moving_right  <= w_dir_right & w_moving_ok;
        r_is_jumping    <= w_launch;
        r_attack_active <= (w_next_state == S_ATK_A);
        r_stunned       <= (w_next_state == S_STUN);
      end else begin
        r_jump_req <= w_jump_pend;
        r_atk_req  <= w_atk_pend;
        r_hit_req  <= w_hit_pend;
      end
    end
  end

  assign bus.movingLeft    = r_moving_left;
  assign bus.movingRight   = r_moving_right;
  assign bus.isJumping     = r_is_jumping;
  assign bus.attack_active = r_attack_active;
  assign bus.stunned       = r_stunned;
  assign bus.state         = r_state;

endmodule

// File: tb/tb_fighter_action_sequencer.sv
// Bench for fighter_action_sequencer: directed scenarios plus random buttons/hits/ticks
// compared against a phase/elapsed-time model of the player.
module tb_fighter_action_sequencer;
  localparam int P_S = 2;
  localparam int P_A = 3;
  localparam int P_R = 4;
  localparam int P_STUN = 6;
  localparam int M_IDLE = 0, M_WALK = 1, M_JUMP = 2, M_ATK = 3, M_STUN = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fighter_action_sequencer_if bus ();

  fighter_action_sequencer #(
    .ATK_STARTUP(P_S), .ATK_ACTIVE(P_A), .ATK_RECOVER(P_R), .STUN_TICKS(P_STUN), .CNT_W(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Model: current phase plus ticks elapsed since entering it.
  int   m_mode = M_IDLE;
  int   m_el = 0;
  logic m_ml = 0, m_mr = 0, m_isj = 0;
  logic m_pj = 0, m_pa = 0, m_ph = 0, m_prevj = 0, m_preva = 0;
  logic m_illegal = 0;

  function automatic logic [2:0] exp_state();
    case (m_mode)
      M_WALK: return 3'd1;
      M_JUMP: return 3'd2;
      M_ATK:  return (m_el < P_S) ? 3'd3 : (m_el < P_S + P_A) ? 3'd4 : 3'd5;
      M_STUN: return 3'd6;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [7:0] exp_vec();
    return {exp_state(), m_ml, m_mr, m_isj, (exp_state() == 3'd4), (m_mode == M_STUN)};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {bus.state, bus.movingLeft, bus.movingRight, bus.isJumping, bus.attack_active, bus.stunned};
  endfunction

  task automatic model_clk();
    logic jp, ap, hp, dl, dr, launch;
    if (!reset) begin
      m_mode = M_IDLE; m_el = 0; m_ml = 0; m_mr = 0; m_isj = 0;
      m_pj = 0; m_pa = 0; m_ph = 0; m_prevj = 0; m_preva = 0; m_illegal = 0;
    end else begin
      jp = m_pj | (bus.btn_jump & ~m_prevj);
      ap = m_pa | (bus.btn_attack & ~m_preva);
      hp = m_ph | bus.hit_in;
      m_prevj = bus.btn_jump;
      m_preva = bus.btn_attack;
      if (bus.tick) begin
        dl = bus.btn_left & ~bus.btn_right;
        dr = bus.btn_right & ~bus.btn_left;
        launch = 0;
        if (m_illegal) begin
          m_mode = M_IDLE; m_illegal = 0;
        end else if (hp && m_mode != M_STUN) begin
          m_mode = M_STUN; m_el = 0;
        end else if (m_mode == M_STUN) begin
          m_el++;
          if (m_el >= P_STUN) m_mode = M_IDLE;
        end else if (m_mode == M_ATK) begin
          m_el++;
          if (m_el >= P_S + P_A + P_R) m_mode = M_IDLE;
        end else if (m_mode == M_JUMP) begin
          m_el++;
          if (bus.on_floor && m_el >= 2) m_mode = M_IDLE;
        end else if (ap) begin
          m_mode = M_ATK; m_el = 0;
        end else if (jp && bus.on_floor) begin
          m_mode = M_JUMP; m_el = 0; launch = 1;
        end else begin
          m_mode = (dl || dr) ? M_WALK : M_IDLE;
        end
        m_isj = launch;
        m_ml = dl && (m_mode == M_WALK || m_mode == M_JUMP);
        m_mr = dr && (m_mode == M_WALK || m_mode == M_JUMP);
        m_pj = 0; m_pa = 0; m_ph = 0;
      end else begin
        m_pj = jp; m_pa = ap; m_ph = hp;
      end
    end
  endtask

  task automatic step(input logic t);
    @(negedge clk);
    bus.tick = t;
    @(posedge clk);
    model_clk();
    #1;
  endtask

  task automatic do_tick();
    step(1'b0);
    step(1'b0);
    step(1'b1);
  endtask

  task automatic pulse_attack();
    bus.btn_attack = 1'b1;
    step(1'b0);
    bus.btn_attack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1);
    n_checks++;
    if (dut_vec() !== 8'h00) begin
      n_fail++; $display("FAIL reset_state: got %b expected %b", dut_vec(), 8'h00);
    end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) do_tick();
    n_checks++;
    if (dut_vec() !== 8'h00) begin
      n_fail++; $display("FAIL idle_after_reset: got %b expected %b", dut_vec(), 8'h00);
    end
  endtask

  task automatic test_walk();
    bus.btn_right = 1'b1;
    do_tick();
    n_checks++;
    if (bus.state !== 3'd1 || bus.movingRight !== 1'b1 || bus.movingLeft !== 1'b0) begin
      n_fail++; $display("FAIL walk_right: state %0d mR %b mL %b expected 1 1 0", bus.state, bus.movingRight, bus.movingLeft);
    end
    bus.btn_left = 1'b1;
    do_tick();
    n_checks++;
    if (dut_vec() !== 8'h00 || exp_vec() !== 8'h00) begin
      n_fail++; $display("FAIL walk_both_cancel: got %b expected %b", dut_vec(), 8'h00);
    end
    bus.btn_left = 1'b0;
    bus.btn_right = 1'b0;
    do_tick();
  endtask

  task automatic test_jump();
    bus.on_floor = 1'b1;
    step(1'b0);
    bus.btn_jump = 1'b1;
    step(1'b0);
    bus.btn_jump = 1'b0;
    step(1'b1);
    n_checks++;
    if (bus.state !== 3'd2 || bus.isJumping !== 1'b1) begin
      n_fail++; $display("FAIL jump_launch: state %0d isJumping %b expected 2 1", bus.state, bus.isJumping);
    end
    bus.on_floor = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        bus.btn_jump = 1'b1;
        step(1'b0);
        bus.btn_jump = 1'b0;
      end
      do_tick();
      n_checks++;
      if (bus.state !== 3'd2 || bus.isJumping !== 1'b0 || dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL jump_airborne[%0d]: got %b expected %b", i, dut_vec(), exp_vec());
      end
    end
    bus.on_floor = 1'b1;
    do_tick();
    n_checks++;
    if (dut_vec() !== 8'h00) begin
      n_fail++; $display("FAIL jump_land: got %b expected %b", dut_vec(), 8'h00);
    end
  endtask

  task automatic test_attack();
    logic [2:0] want;
    pulse_attack();
    for (int t = 1; t <= 10; t++) begin
      bus.btn_jump = (t >= 2 && t <= 8);
      step(1'b0);
      bus.btn_jump = 1'b0;
      step(1'b0);
      step(1'b1);
      want = (t <= 2) ? 3'd3 : (t <= 5) ? 3'd4 : (t <= 9) ? 3'd5 : 3'd0;
      n_checks++;
      if (bus.state !== want || bus.attack_active !== (want == 3'd4) || dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL attack_tick%0d: state %0d active %b expected state %0d", t, bus.state, bus.attack_active, want);
      end
    end
  endtask

  task automatic test_stun();
    pulse_attack();
    for (int i = 0; i < 3; i++) do_tick();
    n_checks++;
    if (bus.state !== 3'd4) begin
      n_fail++; $display("FAIL stun_setup: state %0d expected 4", bus.state);
    end
    for (int t = 1; t <= 7; t++) begin
      bus.hit_in = (t == 1 || t == 3);
      step(1'b0);
      bus.hit_in = 1'b0;
      step(1'b0);
      step(1'b1);
      n_checks++;
      if (bus.stunned !== (t <= 6) || bus.attack_active !== 1'b0 ||
          bus.state !== ((t <= 6) ? 3'd6 : 3'd0) || dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL stun_tick%0d: got %b expected %b", t, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid_and_illegal();
    pulse_attack();
    for (int i = 0; i < 3; i++) do_tick();
    step(1'b0);
    reset = 1'b0;
    step(1'b0);
    n_checks++;
    if (dut_vec() !== 8'h00) begin
      n_fail++; $display("FAIL reset_mid_attack: got %b expected %b", dut_vec(), 8'h00);
    end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      do_tick();
      n_checks++;
      if (bus.attack_active !== 1'b0 || bus.state !== 3'd0) begin
        n_fail++; $display("FAIL post_reset_idle%0d: state %0d active %b expected 0 0", i, bus.state, bus.attack_active);
      end
    end
    force dut.r_state = 3'd7;
    step(1'b0);
    n_checks++;
    if (bus.state !== 3'd7) begin
      n_fail++; $display("FAIL illegal_forced: state %0d expected 7", bus.state);
    end
    release dut.r_state;
    m_illegal = 1'b1;
    step(1'b1);
    n_checks++;
    if (bus.state !== 3'd0 || dut_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL illegal_recover: got %b expected %b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(3) == 0) bus.btn_left = $urandom_range(1);
      if ($urandom_range(3) == 0) bus.btn_right = $urandom_range(1);
      if ($urandom_range(3) == 0) bus.btn_jump = $urandom_range(1);
      if ($urandom_range(5) == 0) bus.btn_attack = $urandom_range(1);
      if ($urandom_range(7) == 0) bus.on_floor = $urandom_range(1);
      bus.hit_in = ($urandom_range(39) == 0);
      reset = ($urandom_range(299) != 0);
      step($urandom_range(2) == 0);
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random_clk%0d: got %b expected %b", i, dut_vec(), exp_vec());
      end
    end
    reset = 1'b1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tick = 1'b0;
    bus.btn_left = 1'b0;
    bus.btn_right = 1'b0;
    bus.btn_jump = 1'b0;
    bus.btn_attack = 1'b0;
    bus.on_floor = 1'b0;
    bus.hit_in = 1'b0;
    test_reset();
    test_walk();
    test_jump();
    test_attack();
    test_stun();
    test_reset_mid_and_illegal();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fighter_action_sequencer.md
Name: fighter_action_sequencer

Overview:
Per-player controller that turns debounced button levels into the movingLeft/movingRight/isJumping commands consumed by the physics engine, and sequences attack and hit-stun phases. It runs on the system clock but advances state only on a shared 20 Hz tick pulse, so the physics engine samples commands that are stable across the whole tick. One instance per player sits between the input block and the physics engine.

Parameters:
ATK_STARTUP, 2, ticks in attack startup (no hitbox)
ATK_ACTIVE, 3, ticks with hitbox live
ATK_RECOVER, 4, ticks of recovery (no movement)
STUN_TICKS, 6, ticks locked out after being hit
CNT_W, 4, phase counter width; every tick parameter must be between 1 and 2^CNT_W-1

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  synchronous, active-low; clk-domain reset
tick  in  1  one-clk-wide pulse at 20 Hz, shared with the physics engine
btn_left  in  1  level, debounced
btn_right  in  1  level, debounced
btn_jump  in  1  level, debounced
btn_attack  in  1  level, debounced
on_floor  in  1  1 when the player's sprite_y equals floor (48)
hit_in  in  1  level; opponent hitbox overlaps this player
movingLeft  out  1  command to the physics engine
movingRight  out  1  command to the physics engine
isJumping  out  1  command to the physics engine, one tick wide
attack_active  out  1  hitbox live (ATK_ACTIVE state)
stunned  out  1  1 in STUN
state  out  3  current state encoding, for renderer and debug

Behaviour:
- Reset (reset==0 at posedge clk): state=IDLE(0); all outputs 0; counter=0; edge latches cleared; previous-button registers=0. Reset overrides tick.
- State encoding: IDLE=0, WALK=1, JUMP=2, ATK_S=3, ATK_A=4, ATK_R=5, STUN=6. Value 7 is illegal; any tick seen in state 7 moves the block to IDLE.
- Edge capture on every clk:
  - jump_req is set on a 0->1 transition of btn_jump.
  - atk_req is set on a 0->1 transition of btn_attack.
  - hit_req is set whenever hit_in==1.
  - All three requests are held until consumed at the next tick and are cleared on that tick edge.
  - A press and a tick on the same clk count as a press pending for that tick.
- State and outputs change only on clk edges where tick==1. Outputs are registered and stay constant between ticks.
- Walk direction, dir: left if btn_left&~btn_right; right if btn_right&~btn_left; none if both or neither.
- Transitions on tick, in priority order:
  1. hit_req in any state except STUN -> STUN, counter=STUN_TICKS-1. hit_req while already in STUN does not reload the counter.
  2. STUN: counter!=0 -> decrement; counter==0 -> IDLE.
  3. ATK_S/ATK_A/ATK_R: decrement counter. On zero, advance ATK_S->ATK_A (load ATK_ACTIVE-1), ATK_A->ATK_R (load ATK_RECOVER-1), ATK_R->IDLE. Requests arriving during an attack are discarded.
  4. IDLE/WALK with atk_req -> ATK_S, counter=ATK_STARTUP-1. Attack is allowed airborne only from IDLE/WALK.
  5. IDLE/WALK with jump_req & on_floor -> JUMP. jump_req while airborne is discarded.
  6. JUMP: on_floor -> IDLE on the first tick after isJumping deasserts. Otherwise stay in JUMP (air control allowed).
  7. IDLE/WALK: dir!=none -> WALK, else IDLE.
- Output decode, registered and updated on the same tick as state:
  - movingLeft/movingRight = dir in WALK and JUMP; 0 elsewhere.
  - isJumping = 1 only on the tick that enters JUMP.
  - attack_active = (state==ATK_A).
  - stunned = (state==STUN).
- Attack total duration = ATK_STARTUP+ATK_ACTIVE+ATK_RECOVER ticks. Stun duration = STUN_TICKS ticks.
- Reset mid-attack or mid-stun: immediate IDLE, with no further attack_active.

Test Plan:
1. Hold reset=0 for 3 clks with tick pulsing -> state=0 and all outputs 0. Release reset, press nothing for 5 ticks -> still IDLE.
2. btn_right=1 -> on the first tick: state=WALK, movingRight=1. Then add btn_left=1 -> on the next tick: state=IDLE, both moving outputs 0.
3. on_floor=1, 1-clk btn_jump pulse mid-tick -> on the next tick isJumping=1 for exactly one tick and state=JUMP. Drop on_floor for 10 ticks, then raise it -> IDLE on the following tick. A second jump press while on_floor=0 is ignored.
4. Attack pulse from IDLE -> ATK_S for 2 ticks, attack_active=1 for exactly ticks 3-5, ATK_R for 4 ticks, IDLE at tick 10. Jump presses during this window are ignored.
5. hit_in pulse during ATK_A -> attack_active drops and stunned=1 on the next tick. Stunned holds for 6 ticks, then IDLE. A second hit_in during STUN does not extend it.
6. Assert reset=0 during ATK_A between ticks -> outputs 0 on the next clk. Force state=7 via a bench override -> IDLE on the next tick.
